// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, sweep bounds and the self-test sequencer states.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_NOT  = 3'b101;
  localparam logic [2:0] ALU_CNT  = 3'b110;
  localparam logic [2:0] ALU_LFSR = 3'b111;

  // Last {sel,A,B} index of the sweep: sel 101, A 111, B 111.
  localparam logic [8:0] LAST_VEC = 9'd383;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the ALU's stateless opcodes: (sel,A,B) -> {exp_c,exp_out}.
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [2:0] sel_i,
  input  logic [2:0] a_i,
  input  logic [2:0] b_i,
  output logic       exp_c_o,
  output logic [7:0] exp_out_o
);

  logic [8:0] a_ext;
  logic [8:0] b_ext;
  logic [8:0] res;

  assign a_ext = {6'd0, a_i};
  assign b_ext = {6'd0, b_i};

  always_comb begin
    res = 9'd0;
    case (sel_i)
      ALU_ADD: res = a_ext + b_ext;
      // Borrow lands in bit 8, so A<B reports carry=1.
      ALU_SUB: res = a_ext - b_ext;
      ALU_AND: res = a_ext & b_ext;
      ALU_OR:  res = a_ext | b_ext;
      ALU_XOR: res = a_ext ^ b_ext;
      ALU_NOT: res = {4'b0111, 2'b11, ~a_i};
      default: res = 9'd0;
    endcase
  end

  assign {exp_c_o, exp_out_o} = res;

endmodule

// File: rtl/alu_self_test_seq.sv
// Power-on ALU self-test: sweeps opcodes 000..101 over all operand pairs, compares
// against alu_ref_model and reports pass, error count and the first failing vector.
module alu_self_test_seq
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES     = 4,
  parameter bit STOP_ON_FIRST_ERR = 1'b0
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       start,
  output logic [2:0] A_drv,
  output logic [2:0] B_drv,
  output logic [2:0] ALU_Sel_drv,
  input  logic [7:0] alu_out_in,
  input  logic       carry_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_count,
  output logic       first_err_vld,
  output logic [8:0] first_err_vec
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  state_e        state_q, state_d;
  logic [8:0]    vec_q, vec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [8:0]    err_q, err_d;
  logic          fvld_q, fvld_d;
  logic [8:0]    fvec_q, fvec_d;

  logic       exp_c;
  logic [7:0] exp_out;
  logic       mismatch;

  alu_ref_model u_ref (
    .sel_i     (vec_q[8:6]),
    .a_i       (vec_q[5:3]),
    .b_i       (vec_q[2:0]),
    .exp_c_o   (exp_c),
    .exp_out_o (exp_out)
  );

  assign mismatch = {carry_in, alu_out_in} != {exp_c, exp_out};

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fvld_d  = fvld_q;
    fvec_d  = fvec_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SETTLE;
          vec_d   = 9'd0;
          cnt_d   = '0;
          err_d   = 9'd0;
          fvld_d  = 1'b0;
          fvec_d  = 9'd0;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == SETTLE_LAST) state_d = CHECK;
      end
      CHECK: begin
        if (mismatch) begin
          if (err_q != 9'h1FF) err_d = err_q + 9'd1;
          if (!fvld_q) begin
            fvld_d = 1'b1;
            fvec_d = vec_q;
          end
        end
        if (vec_q == LAST_VEC || (STOP_ON_FIRST_ERR && mismatch)) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 9'd1;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= 9'd0;
      cnt_q   <= '0;
      err_q   <= 9'd0;
      fvld_q  <= 1'b0;
      fvec_q  <= 9'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fvld_q  <= fvld_d;
      fvec_q  <= fvec_d;
    end
  end

  assign ALU_Sel_drv   = vec_q[8:6];
  assign A_drv         = vec_q[5:3];
  assign B_drv         = vec_q[2:0];
  assign busy          = (state_q == SETTLE) || (state_q == CHECK);
  assign done          = (state_q == DONE);
  assign pass          = done && (err_q == 9'd0);
  assign err_count     = err_q;
  assign first_err_vld = fvld_q;
  assign first_err_vec = fvec_q;

endmodule

// File: tb/tb_alu_self_test_seq.sv
// Bench for alu_self_test_seq: behavioural ALU with injectable faults drives two sequencers
// (full sweep and stop-on-first-error); results are checked against arithmetic expectations.
module tb_alu_self_test_seq;

  localparam int S = 4;
  localparam int BOUND = 5000;

  logic clk_50MHz = 1'b0;
  always #10 clk_50MHz = ~clk_50MHz;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       start_s = 1'b0;

  logic [2:0] a_m, b_m, sel_m, a_s, b_s, sel_s;
  logic [7:0] out_m, out_s;
  logic       c_m, c_s;
  logic       busy_m, done_m, pass_m, fvld_m;
  logic [8:0] errc_m, fvec_m;
  logic       busy_s, done_s, pass_s, fvld_s;
  logic [8:0] errc_s, fvec_s;

  int         fault_mode = 0;
  logic [8:0] xor_tab [0:511];

  int checks = 0;
  int failures = 0;

  alu_self_test_seq #(.SETTLE_CYCLES(S), .STOP_ON_FIRST_ERR(1'b0)) dut (
    .clk_50MHz(clk_50MHz), .reset(reset), .start(start),
    .A_drv(a_m), .B_drv(b_m), .ALU_Sel_drv(sel_m),
    .alu_out_in(out_m), .carry_in(c_m),
    .busy(busy_m), .done(done_m), .pass(pass_m), .err_count(errc_m),
    .first_err_vld(fvld_m), .first_err_vec(fvec_m)
  );

  alu_self_test_seq #(.SETTLE_CYCLES(S), .STOP_ON_FIRST_ERR(1'b1)) dut_stop (
    .clk_50MHz(clk_50MHz), .reset(reset), .start(start_s),
    .A_drv(a_s), .B_drv(b_s), .ALU_Sel_drv(sel_s),
    .alu_out_in(out_s), .carry_in(c_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(errc_s),
    .first_err_vld(fvld_s), .first_err_vec(fvec_s)
  );

  // Reference ALU from the operation definitions, result as 9-bit {carry,out}.
  function automatic logic [8:0] golden(input int sel, input int a, input int b);
    int r;
    case (sel)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 248 + (7 - a);
      default: r = 0;
    endcase
    return 9'(r & 511);
  endfunction

  function automatic logic [8:0] alu_resp(input logic [2:0] sel, input logic [2:0] a,
                                          input logic [2:0] b, input int mode,
                                          input logic [8:0] x);
    logic [8:0] r;
    r = golden(int'(sel), int'(a), int'(b));
    if (mode == 1 && sel == 3'd1) r[8] = 1'b0;
    if (mode == 2) r[7] = 1'b0;
    if (mode == 3) r = r ^ x;
    return r;
  endfunction

  always_comb {c_m, out_m} = alu_resp(sel_m, a_m, b_m, fault_mode, xor_tab[{sel_m, a_m, b_m}]);
  always_comb {c_s, out_s} = alu_resp(sel_s, a_s, b_s, fault_mode, xor_tab[{sel_s, a_s, b_s}]);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start on the chosen instance and count edges from the start edge until done.
  // glitch_at > 0 re-pulses start that many edges into the run.
  task automatic run(input bit stop_inst, input int glitch_at, output int cycles, output int busy_cnt);
    @(negedge clk_50MHz);
    if (stop_inst) start_s = 1'b1; else start = 1'b1;
    @(negedge clk_50MHz);
    start = 1'b0;
    start_s = 1'b0;
    cycles = 0;
    busy_cnt = 0;
    while (!(stop_inst ? done_s : done_m) && cycles < BOUND) begin
      if (stop_inst ? busy_s : busy_m) busy_cnt++;
      if (glitch_at > 0 && cycles == glitch_at) begin
        if (stop_inst) start_s = 1'b1; else start = 1'b1;
      end else begin
        start = 1'b0;
        start_s = 1'b0;
      end
      @(negedge clk_50MHz);
      cycles++;
    end
    start = 1'b0;
    start_s = 1'b0;
    chk("run_bound", 32'(cycles < BOUND), 32'd1);
  endtask

  function automatic logic [31:0] all_outs_m();
    return 32'({sel_m, a_m, b_m, busy_m, done_m, pass_m, errc_m, fvld_m, fvec_m});
  endfunction

  function automatic logic [31:0] all_outs_s();
    return 32'({sel_s, a_s, b_s, busy_s, done_s, pass_s, errc_s, fvld_s, fvec_s});
  endfunction

  initial begin
    int cyc, bcnt, exp_err, exp_first, k, idx;
    for (int i = 0; i < 512; i++) xor_tab[i] = 9'd0;

    // Reset state
    repeat (3) @(negedge clk_50MHz);
    chk("reset_main", all_outs_m(), 32'd0);
    chk("reset_stop", all_outs_s(), 32'd0);
    reset = 1'b0;

    // Correct ALU, full sweep
    run(1'b0, 0, cyc, bcnt);
    chk("t1_len", cyc, 32'd1920);
    chk("t1_busy", bcnt, 32'd1920);
    chk("t1_pass", {done_m, pass_m, fvld_m}, 3'b110);
    chk("t1_err", errc_m, 9'd0);
    chk("t1_fvec", fvec_m, 9'd0);
    chk("t1_drv", {sel_m, a_m, b_m}, 9'd383);

    // SUB carry stuck 0, with a start glitch mid-run
    fault_mode = 1;
    run(1'b0, $urandom_range(10, 1800), cyc, bcnt);
    chk("t2_len", cyc, 32'd1920);
    chk("t2_err", errc_m, 9'd28);
    chk("t2_fvec", fvec_m, 9'h041);
    chk("t2_flags", {done_m, pass_m, fvld_m}, 3'b101);

    // Restart from DONE with a healthy ALU
    fault_mode = 0;
    run(1'b0, 0, cyc, bcnt);
    chk("t6_restart", {done_m, pass_m, fvld_m, errc_m}, {3'b110, 9'd0});

    // ALU_Out[7] stuck 0
    fault_mode = 2;
    run(1'b0, 0, cyc, bcnt);
    chk("t3_err", errc_m, 9'd92);
    chk("t3_fvec", fvec_m, 9'h041);
    chk("t3_pass", pass_m, 1'b0);

    // Stop on first error
    fault_mode = 1;
    run(1'b1, 0, cyc, bcnt);
    chk("t4_len", cyc, 32'd330);
    chk("t4_err", errc_s, 9'd1);
    chk("t4_drv", {sel_s, a_s, b_s}, 9'h041);
    chk("t4_fvec", {fvld_s, fvec_s}, {1'b1, 9'h041});

    // Reset 100 cycles into a run, then a same-cycle start+reset
    fault_mode = 0;
    @(negedge clk_50MHz);
    start = 1'b1;
    @(negedge clk_50MHz);
    start = 1'b0;
    repeat (99) @(negedge clk_50MHz);
    chk("t5_midrun_busy", busy_m, 1'b1);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk_50MHz);
    chk("t5_reset_main", all_outs_m(), 32'd0);
    chk("t5_reset_stop", all_outs_s(), 32'd0);
    start = 1'b0;
    reset = 1'b0;
    run(1'b0, 0, cyc, bcnt);
    chk("t5_len", cyc, 32'd1920);
    chk("t5_pass", {done_m, pass_m, errc_m}, {2'b11, 9'd0});

    // Random corrupted vectors
    fault_mode = 3;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 512; i++) xor_tab[i] = 9'd0;
      k = $urandom_range(1, 6);
      for (int j = 0; j < k; j++) begin
        idx = $urandom_range(0, 383);
        xor_tab[idx] = 9'($urandom_range(1, 511));
      end
      exp_err = 0;
      exp_first = -1;
      for (int v = 0; v < 384; v++) begin
        if (xor_tab[v] != 9'd0) begin
          exp_err++;
          if (exp_first < 0) exp_first = v;
        end
      end
      run(1'b0, $urandom_range(1, 1900), cyc, bcnt);
      chk("rnd_len", cyc, 32'd1920);
      chk("rnd_err", errc_m, 32'(exp_err));
      chk("rnd_fvec", {fvld_m, fvec_m}, {1'b1, 9'(exp_first)});
      chk("rnd_pass", pass_m, 1'b0);
      run(1'b1, 0, cyc, bcnt);
      chk("rnd_stop_len", cyc, 32'((exp_first + 1) * (S + 1)));
      chk("rnd_stop_err", errc_s, 9'd1);
      chk("rnd_stop_drv", {sel_s, a_s, b_s}, 9'(exp_first));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
